// File: rtl/xui_pkg.sv
// xui_pkg: shared encodings for the XUI responder.
//   XUI_CMD_WR / XUI_CMD_RD : app_cmd encodings (every other value is illegal)
//   xui_state_e             : engine FSM states
package xui_pkg;

  localparam logic [2:0] XUI_CMD_WR = 3'b000;
  localparam logic [2:0] XUI_CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    ST_CALIB   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RDBURST = 2'd2
  } xui_state_e;

endpackage

// File: rtl/xui_if.sv
// xui_if: application-side bus of the XUI responder.
//   command : app_addr, app_cmd, app_en -> app_rdy
//   wr data : app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end -> app_wdf_rdy
//   rd data : app_rd_data, app_rd_data_valid, app_rd_data_end
//   status  : init_calib_complete, cmd_err
// master = application (drives commands), slave = responder.
interface xui_if #(
  parameter int ADDR_SIZE = 31,
  parameter int DATA_SIZE = 64
);
  logic [ADDR_SIZE-1:0]   app_addr;
  logic [2:0]             app_cmd;
  logic                   app_en;
  logic                   app_rdy;
  logic [DATA_SIZE-1:0]   app_wdf_data;
  logic [DATA_SIZE/8-1:0] app_wdf_mask;
  logic                   app_wdf_wren;
  logic                   app_wdf_end;
  logic                   app_wdf_rdy;
  logic [DATA_SIZE-1:0]   app_rd_data;
  logic                   app_rd_data_valid;
  logic                   app_rd_data_end;
  logic                   init_calib_complete;
  logic                   cmd_err;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete, cmd_err
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete, cmd_err
  );
endinterface

// File: rtl/xui_syncfifo.sv
// xui_syncfifo: single-clock first-word-fall-through FIFO.
//   clk, rst       : clock, async active-high reset (empties the FIFO)
//   push_i, din_i  : write side; a push while full is dropped
//   pop_i, dout_o  : read side; dout_o shows the head entry whenever !empty_o
//   full_o,empty_o : occupancy flags
module xui_syncfifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH_LG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int DEPTH = 1 << DEPTH_LG;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [DEPTH_LG:0] wptr_q, rptr_q;
  logic              full, empty, do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[DEPTH_LG] != rptr_q[DEPTH_LG]) &&
                   (wptr_q[DEPTH_LG-1:0] == rptr_q[DEPTH_LG-1:0]);
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (DEPTH_LG+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (DEPTH_LG+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[DEPTH_LG-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q[DEPTH_LG-1:0]];
  assign full_o  = full;
  assign empty_o = empty;
endmodule

// File: rtl/xui_responder.sv
// xui_responder: behavioural memory-controller responder on the XUI app bus.
//   clk, reset : single clock, async active-high reset
//   bus        : xui_if slave (command, write data, read data, status)
// After CAL_CYCLES cycles it accepts commands and write beats into two
// in-order queues. The engine executes writes (one cycle, byte-masked) and
// reads (RD_BEATS consecutive words, wrapping) against a 2^MEM_LG word store;
// read beats emerge RD_LATENCY cycles after issue.
module xui_responder
  import xui_pkg::*;
#(
  parameter int ADDR_SIZE  = 31,
  parameter int DATA_SIZE  = 64,
  parameter int MEM_LG     = 10,
  parameter int CAL_CYCLES = 16,
  parameter int RD_LATENCY = 4,
  parameter int RD_BEATS   = 8,
  parameter int QDEPTH_LG  = 2
) (
  input  logic clk,
  input  logic reset,
  xui_if.slave bus
);
  localparam int NB    = DATA_SIZE / 8;
  localparam int OFF   = $clog2(NB);
  localparam int DEPTH = 1 << MEM_LG;
  localparam int BW    = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;
  localparam int CW    = $clog2(CAL_CYCLES + 1);
  localparam int CMDW  = 3 + MEM_LG;
  localparam int DATW  = NB + DATA_SIZE;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RD_BEATS - 1);

  // ---------------- calibration ----------------
  logic [CW-1:0] cal_cnt_q;
  logic          calib_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cal_cnt_q <= '0;
      calib_q   <= 1'b0;
    end else if (!calib_q) begin
      cal_cnt_q <= cal_cnt_q + CW'(1);
      if (cal_cnt_q == CW'(CAL_CYCLES - 1)) calib_q <= 1'b1;
    end
  end

  // ---------------- queues ----------------
  // Commands are stored as {cmd, word index}; the byte offset and the
  // address bits above the store depth never matter again.
  logic [MEM_LG-1:0] req_idx;
  logic              cmd_rdy, dat_rdy, cmd_push, dat_push, cmd_pop, dat_pop;
  logic              cmd_full, cmd_empty, dat_full, dat_empty;
  logic [CMDW-1:0]   cmd_head;
  logic [DATW-1:0]   dat_head;
  logic              unused_ok;

  assign req_idx   = bus.app_addr[OFF +: MEM_LG];
  assign cmd_rdy   = calib_q & ~cmd_full;
  assign dat_rdy   = calib_q & ~dat_full;
  assign cmd_push  = bus.app_en & cmd_rdy;
  assign dat_push  = bus.app_wdf_wren & dat_rdy;
  // app_wdf_end carries no information: every write owns exactly one beat.
  assign unused_ok = ^{bus.app_wdf_end, bus.app_addr};

  xui_syncfifo #(.WIDTH(CMDW), .DEPTH_LG(QDEPTH_LG)) u_cmdq (
    .clk(clk), .rst(reset),
    .push_i(cmd_push), .din_i({bus.app_cmd, req_idx}),
    .pop_i(cmd_pop), .dout_o(cmd_head),
    .full_o(cmd_full), .empty_o(cmd_empty)
  );

  xui_syncfifo #(.WIDTH(DATW), .DEPTH_LG(QDEPTH_LG)) u_datq (
    .clk(clk), .rst(reset),
    .push_i(dat_push), .din_i({bus.app_wdf_mask, bus.app_wdf_data}),
    .pop_i(dat_pop), .dout_o(dat_head),
    .full_o(dat_full), .empty_o(dat_empty)
  );

  logic [2:0]           hd_cmd;
  logic [MEM_LG-1:0]    hd_idx;
  logic [NB-1:0]        hd_mask;
  logic [DATA_SIZE-1:0] hd_wdata;

  assign hd_cmd   = cmd_head[CMDW-1 -: 3];
  assign hd_idx   = cmd_head[MEM_LG-1:0];
  assign hd_mask  = dat_head[DATW-1 -: NB];
  assign hd_wdata = dat_head[DATA_SIZE-1:0];

  // ---------------- engine FSM ----------------
  xui_state_e state_q, state_d;
  logic [MEM_LG-1:0] base_q;
  logic [BW-1:0]     beat_q;
  logic              cmd_err_q;
  logic              wr_en, rd_start, err_set, issue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_CALIB;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CALIB:   if (calib_q) state_d = ST_IDLE;
      ST_IDLE:    if (!cmd_empty && hd_cmd == XUI_CMD_RD) state_d = ST_RDBURST;
      ST_RDBURST: if (beat_q == LAST_BEAT) state_d = ST_IDLE;
      default:    state_d = ST_CALIB;
    endcase
  end

  always_comb begin
    cmd_pop  = 1'b0;
    dat_pop  = 1'b0;
    wr_en    = 1'b0;
    rd_start = 1'b0;
    err_set  = 1'b0;
    issue    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cmd_empty) begin
          case (hd_cmd)
            XUI_CMD_WR: begin
              // A write waits at the head until its data beat is available.
              if (!dat_empty) begin
                wr_en   = 1'b1;
                cmd_pop = 1'b1;
                dat_pop = 1'b1;
              end
            end
            XUI_CMD_RD: begin
              cmd_pop  = 1'b1;
              rd_start = 1'b1;
            end
            default: begin
              cmd_pop = 1'b1;
              err_set = 1'b1;
            end
          endcase
        end
      end
      ST_RDBURST: issue = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q    <= '0;
      beat_q    <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      if (rd_start) begin
        base_q <= hd_idx;
        beat_q <= '0;
      end else if (issue) begin
        beat_q <= beat_q + BW'(1);
      end
      if (err_set) cmd_err_q <= 1'b1;
    end
  end

  // ---------------- backing store ----------------
  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [MEM_LG-1:0]    rd_idx;

  // Index arithmetic wraps naturally at the store depth.
  assign rd_idx = base_q + MEM_LG'(beat_q);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (!hd_mask[b]) mem_q[hd_idx][8*b +: 8] <= hd_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read return pipeline ----------------
  // Stage 1 captures the issued word; stage RD_LATENCY drives the bus.
  logic [RD_LATENCY:1]                vld_pipe_q, end_pipe_q;
  logic [RD_LATENCY:1][DATA_SIZE-1:0] dat_pipe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      end_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= issue;
      end_pipe_q[1] <= issue & (beat_q == LAST_BEAT);
      dat_pipe_q[1] <= issue ? mem_q[rd_idx] : '0;
      for (int s = 2; s <= RD_LATENCY; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        end_pipe_q[s] <= end_pipe_q[s-1];
        dat_pipe_q[s] <= dat_pipe_q[s-1];
      end
    end
  end

  assign bus.app_rdy             = cmd_rdy;
  assign bus.app_wdf_rdy         = dat_rdy;
  assign bus.app_rd_data         = dat_pipe_q[RD_LATENCY];
  assign bus.app_rd_data_valid   = vld_pipe_q[RD_LATENCY];
  assign bus.app_rd_data_end     = end_pipe_q[RD_LATENCY];
  assign bus.init_calib_complete = calib_q;
  assign bus.cmd_err             = cmd_err_q;
endmodule

// File: tb/tb_xui_responder.sv
// tb_xui_responder: self-checking bench for xui_responder.
// A word-array reference memory (with per-word "known" flags) predicts read
// data; expected latency is derived from: accept edge -> head popped next
// cycle -> first beat issued the cycle after -> data RD_LATENCY cycles later.
module tb_xui_responder;
  import xui_pkg::*;

  localparam int AW     = 31;
  localparam int DW     = 64;
  localparam int NB     = DW / 8;
  localparam int MEM_LG = 10;
  localparam int DEPTH  = 1 << MEM_LG;
  localparam int RD_LAT = 4;
  localparam int BEATS  = 8;
  localparam int CAL    = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  xui_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) ifc ();

  xui_responder #(
    .ADDR_SIZE(AW), .DATA_SIZE(DW), .MEM_LG(MEM_LG), .CAL_CYCLES(CAL),
    .RD_LATENCY(RD_LAT), .RD_BEATS(BEATS), .QDEPTH_LG(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(ifc)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] ref_mem   [DEPTH];
  bit            ref_known [DEPTH];

  logic [DW-1:0] mon_data [$];
  bit            mon_end  [$];
  int            mon_cyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && ifc.app_rd_data_valid) begin
      mon_data.push_back(ifc.app_rd_data);
      mon_end.push_back(ifc.app_rd_data_end);
      mon_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- model and drivers ----------------
  function automatic int widx(input logic [AW-1:0] a);
    return int'(a >> 3) % DEPTH;
  endfunction

  task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] m);
    int w;
    w = widx(a);
    for (int b = 0; b < NB; b++) if (!m[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    if (m == '0) ref_known[w] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    mon_data.delete();
    mon_end.delete();
    mon_cyc.delete();
  endtask

  // Called at a negedge; returns the edge index that accepts the command.
  task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a, output int acc);
    int n;
    n = 0;
    ifc.app_cmd  = c;
    ifc.app_addr = a;
    ifc.app_en   = 1'b1;
    while (!ifc.app_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL send_cmd_timeout: app_rdy stayed %b, required 1", ifc.app_rdy);
    end
    @(negedge clk);
    ifc.app_en = 1'b0;
  endtask

  task automatic send_data(input logic [DW-1:0] d, input logic [NB-1:0] m);
    int n;
    n = 0;
    ifc.app_wdf_data = d;
    ifc.app_wdf_mask = m;
    ifc.app_wdf_end  = 1'b1;
    ifc.app_wdf_wren = 1'b1;
    while (!ifc.app_wdf_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL send_data_timeout: app_wdf_rdy stayed %b, required 1", ifc.app_wdf_rdy);
    end
    @(negedge clk);
    ifc.app_wdf_wren = 1'b0;
    ifc.app_wdf_end  = 1'b0;
  endtask

  task automatic wait_beats(input int n, output bit ok);
    int t;
    t = 0;
    while (mon_data.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    ok = (mon_data.size() >= n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ifc.app_rdy !== 1'b0) begin errors++; $display("FAIL reset_app_rdy: got %b required 0", ifc.app_rdy); end
    checks++; if (ifc.app_wdf_rdy !== 1'b0) begin errors++; $display("FAIL reset_wdf_rdy: got %b required 0", ifc.app_wdf_rdy); end
    checks++; if (ifc.app_rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", ifc.app_rd_data_valid); end
    checks++; if (ifc.app_rd_data_end !== 1'b0) begin errors++; $display("FAIL reset_end: got %b required 0", ifc.app_rd_data_end); end
    checks++; if (ifc.app_rd_data !== '0) begin errors++; $display("FAIL reset_data: got %h required 0", ifc.app_rd_data); end
    checks++; if (ifc.init_calib_complete !== 1'b0) begin errors++; $display("FAIL reset_calib: got %b required 0", ifc.init_calib_complete); end
    checks++; if (ifc.cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b required 0", ifc.cmd_err); end
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++; if (ifc.init_calib_complete !== (i >= CAL)) begin errors++; $display("FAIL calib_cycle%0d: got %b required %b", i, ifc.init_calib_complete, (i >= CAL)); end
      checks++; if (ifc.app_rdy !== (i >= CAL)) begin errors++; $display("FAIL rdy_cycle%0d: got %b required %b", i, ifc.app_rdy, (i >= CAL)); end
      checks++; if (ifc.app_wdf_rdy !== (i >= CAL)) begin errors++; $display("FAIL wdf_rdy_cycle%0d: got %b required %b", i, ifc.app_wdf_rdy, (i >= CAL)); end
    end
  endtask

  task automatic test_write_read();
    int acc;
    bit ok;
    logic [DW-1:0] d;
    d = 64'h1122334455667788;
    send_cmd(XUI_CMD_WR, AW'(32'h40), acc);
    send_data(d, 8'h00);
    ref_write(AW'(32'h40), d, 8'h00);
    idle(4);
    clear_mon();
    send_cmd(XUI_CMD_RD, AW'(32'h40), acc);
    wait_beats(BEATS, ok);
    idle(4);
    checks++; if (!ok || mon_data.size() != BEATS) begin errors++; $display("FAIL wr_rd_count: got %0d beats required %0d", mon_data.size(), BEATS); end
    if (ok) begin
      checks++; if (mon_cyc[0] != acc + 1 + RD_LAT) begin errors++; $display("FAIL wr_rd_latency: first beat at cycle %0d required %0d", mon_cyc[0], acc + 1 + RD_LAT); end
      checks++; if (mon_data[0] !== d) begin errors++; $display("FAIL wr_rd_data: got %h required %h", mon_data[0], d); end
      for (int i = 0; i < BEATS; i++) begin
        checks++; if (mon_cyc[i] != mon_cyc[0] + i) begin errors++; $display("FAIL wr_rd_contig%0d: cycle %0d required %0d", i, mon_cyc[i], mon_cyc[0] + i); end
        checks++; if (mon_end[i] !== (i == BEATS - 1)) begin errors++; $display("FAIL wr_rd_end%0d: got %b required %b", i, mon_end[i], (i == BEATS - 1)); end
      end
    end
  endtask

  task automatic test_mask();
    int acc;
    bit ok;
    send_cmd(XUI_CMD_WR, AW'(32'h80), acc);
    send_data(64'h0, 8'h00);
    ref_write(AW'(32'h80), 64'h0, 8'h00);
    send_cmd(XUI_CMD_WR, AW'(32'h80), acc);
    send_data(64'hFFFF_FFFF_FFFF_FFFF, 8'hF0);
    ref_write(AW'(32'h80), 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0);
    idle(4);
    clear_mon();
    send_cmd(XUI_CMD_RD, AW'(32'h80), acc);
    wait_beats(BEATS, ok);
    idle(4);
    checks++; if (!ok || mon_data.size() != BEATS) begin errors++; $display("FAIL mask_count: got %0d beats required %0d", mon_data.size(), BEATS); end
    if (ok) begin
      checks++; if (mon_data[0] !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL mask_data: got %h required 00000000ffffffff", mon_data[0]); end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    bit ok;
    logic [DW-1:0] wd [4];
    for (int i = 0; i < 4; i++) send_cmd(XUI_CMD_WR, AW'(32'h100 + 8 * i), acc);
    checks++; if (ifc.app_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_drop: got %b required 0", ifc.app_rdy); end
    idle(3);
    checks++; if (ifc.app_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_hold: got %b required 0", ifc.app_rdy); end
    checks++; if (ifc.app_wdf_rdy !== 1'b1) begin errors++; $display("FAIL bp_wdf_rdy: got %b required 1", ifc.app_wdf_rdy); end
    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom};
      send_data(wd[i], 8'h00);
      ref_write(AW'(32'h100 + 8 * i), wd[i], 8'h00);
    end
    idle(4);
    checks++; if (ifc.app_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_return: got %b required 1", ifc.app_rdy); end
    clear_mon();
    send_cmd(XUI_CMD_RD, AW'(32'h100), acc);
    wait_beats(BEATS, ok);
    idle(4);
    checks++; if (!ok || mon_data.size() != BEATS) begin errors++; $display("FAIL bp_count: got %0d beats required %0d", mon_data.size(), BEATS); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (mon_data[i] !== wd[i]) begin errors++; $display("FAIL bp_order%0d: got %h required %h", i, mon_data[i], wd[i]); end
      end
    end
  endtask

  task automatic test_wrap();
    int acc, w;
    bit ok;
    logic [DW-1:0] wd [BEATS];
    for (int i = 0; i < BEATS; i++) begin
      w = (1020 + i) % DEPTH;
      wd[i] = {$urandom, $urandom};
      send_cmd(XUI_CMD_WR, AW'(w * 8), acc);
      send_data(wd[i], 8'h00);
      ref_write(AW'(w * 8), wd[i], 8'h00);
    end
    idle(4);
    clear_mon();
    send_cmd(XUI_CMD_RD, AW'(1020 * 8), acc);
    wait_beats(BEATS, ok);
    idle(4);
    checks++; if (!ok || mon_data.size() != BEATS) begin errors++; $display("FAIL wrap_count: got %0d beats required %0d", mon_data.size(), BEATS); end
    if (ok) begin
      for (int i = 0; i < BEATS; i++) begin
        checks++; if (mon_data[i] !== wd[i]) begin errors++; $display("FAIL wrap_beat%0d: got %h required %h", i, mon_data[i], wd[i]); end
      end
    end
  endtask

  task automatic test_illegal();
    int acc;
    bit ok;
    clear_mon();
    send_cmd(3'b010, AW'(32'h40), acc);
    idle(20);
    checks++; if (ifc.cmd_err !== 1'b1) begin errors++; $display("FAIL illegal_cmd_err: got %b required 1", ifc.cmd_err); end
    checks++; if (mon_data.size() != 0) begin errors++; $display("FAIL illegal_no_data: got %0d beats required 0", mon_data.size()); end
    send_cmd(XUI_CMD_RD, AW'(32'h40), acc);
    wait_beats(BEATS, ok);
    idle(4);
    checks++; if (!ok || mon_data.size() != BEATS) begin errors++; $display("FAIL illegal_next_count: got %0d beats required %0d", mon_data.size(), BEATS); end
    if (ok) begin
      checks++; if (mon_data[0] !== ref_mem[widx(AW'(32'h40))]) begin errors++; $display("FAIL illegal_next_data: got %h required %h", mon_data[0], ref_mem[widx(AW'(32'h40))]); end
    end
  endtask

  task automatic test_back_to_back();
    int acc, w;
    bit ok;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [NB-1:0] m;
    logic [DW-1:0] exp_d [$];
    bit            exp_k [$];
    clear_mon();
    for (int i = 0; i < 20; i++) begin
      a = AW'($urandom);
      a[3 +: MEM_LG] = MEM_LG'($urandom_range(0, 23));
      if ($urandom_range(0, 2) != 0) begin
        d = {$urandom, $urandom};
        m = ($urandom_range(0, 2) == 0) ? NB'($urandom) : '0;
        if ($urandom_range(0, 1) == 1) begin
          send_data(d, m);
          send_cmd(XUI_CMD_WR, a, acc);
        end else begin
          send_cmd(XUI_CMD_WR, a, acc);
          send_data(d, m);
        end
        ref_write(a, d, m);
      end else begin
        send_cmd(XUI_CMD_RD, a, acc);
        for (int j = 0; j < BEATS; j++) begin
          w = (widx(a) + j) % DEPTH;
          exp_d.push_back(ref_mem[w]);
          exp_k.push_back(ref_known[w]);
        end
      end
    end
    wait_beats(exp_d.size(), ok);
    idle(20);
    checks++; if (mon_data.size() != exp_d.size()) begin errors++; $display("FAIL b2b_count: got %0d beats required %0d", mon_data.size(), exp_d.size()); end
    if (ok) begin
      for (int i = 0; i < exp_d.size(); i++) begin
        if (exp_k[i]) begin
          checks++; if (mon_data[i] !== exp_d[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h required %h", i, mon_data[i], exp_d[i]); end
        end
        checks++; if (mon_end[i] !== ((i % BEATS) == BEATS - 1)) begin errors++; $display("FAIL b2b_end%0d: got %b required %b", i, mon_end[i], ((i % BEATS) == BEATS - 1)); end
      end
    end
  endtask

  task automatic test_reset_burst();
    int acc, t;
    bit ok;
    clear_mon();
    send_cmd(XUI_CMD_RD, AW'(32'h40), acc);
    t = 0;
    while (!ifc.app_rd_data_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++; if (ifc.app_rd_data_valid !== 1'b1) begin errors++; $display("FAIL rst_burst_start: valid %b required 1", ifc.app_rd_data_valid); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (ifc.app_rd_data_valid !== 1'b0) begin errors++; $display("FAIL rst_burst_valid: got %b required 0", ifc.app_rd_data_valid); end
    checks++; if (ifc.app_rd_data_end !== 1'b0) begin errors++; $display("FAIL rst_burst_end: got %b required 0", ifc.app_rd_data_end); end
    checks++; if (ifc.app_rd_data !== '0) begin errors++; $display("FAIL rst_burst_data: got %h required 0", ifc.app_rd_data); end
    checks++; if (ifc.init_calib_complete !== 1'b0) begin errors++; $display("FAIL rst_burst_calib: got %b required 0", ifc.init_calib_complete); end
    checks++; if (ifc.cmd_err !== 1'b0) begin errors++; $display("FAIL rst_burst_cmd_err: got %b required 0", ifc.cmd_err); end
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    idle(CAL + 12);
    checks++; if (mon_data.size() != 0) begin errors++; $display("FAIL rst_burst_dropped: got %0d beats required 0", mon_data.size()); end
    checks++; if (ifc.app_rdy !== 1'b1) begin errors++; $display("FAIL rst_burst_recal: app_rdy %b required 1", ifc.app_rdy); end
    // The store keeps its contents across reset.
    send_cmd(XUI_CMD_RD, AW'(32'h40), acc);
    wait_beats(BEATS, ok);
    idle(4);
    checks++; if (!ok || mon_data.size() != BEATS) begin errors++; $display("FAIL rst_keep_count: got %0d beats required %0d", mon_data.size(), BEATS); end
    if (ok) begin
      checks++; if (mon_data[0] !== ref_mem[widx(AW'(32'h40))]) begin errors++; $display("FAIL rst_keep_data: got %h required %h", mon_data[0], ref_mem[widx(AW'(32'h40))]); end
    end
  endtask

  initial begin
    ifc.app_addr     = '0;
    ifc.app_cmd      = '0;
    ifc.app_en       = 1'b0;
    ifc.app_wdf_data = '0;
    ifc.app_wdf_mask = '0;
    ifc.app_wdf_wren = 1'b0;
    ifc.app_wdf_end  = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
    test_reset();
    test_write_read();
    test_mask();
    test_backpressure();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_reset_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
